// File: rtl/core_clk_pkg.sv
// core_clk_pkg: shared types and default constants for the core clock/reset slice.
//   state_e        - reset sequencer states (wait for lock, hold-off, run)
//   HoldCyclesDef  - default synced-lock hold time before reset release
//   CeDivDef       - default clock-enable period in clk cycles
package core_clk_pkg;

    typedef enum logic [1:0] {
        StWaitLock  = 2'd0,
        StStabilize = 2'd1,
        StRun       = 2'd2
    } state_e;

    localparam int unsigned HoldCyclesDef = 1024;
    localparam int unsigned CeDivDef      = 8;

endpackage

// File: rtl/core_rst_ce_gen_if.sv
// core_rst_ce_gen_if: lock input, sticky clear and reset/enable outputs of the sequencer.
//   dcm_ready  - DCM lock (asynchronous to clk)
//   lock_clr   - synchronous clear of lock_lost
//   sys_rst    - active-high core reset
//   ce/ce_half - one-cycle enable pulses at period end / mid-period
//   running    - sequencer is in its run state
//   lock_lost  - sticky flag: lock dropped while running
// master: the side supplying lock/clear and consuming reset/enables.
// slave : the sequencer itself.
interface core_rst_ce_gen_if;
    logic dcm_ready;
    logic lock_clr;
    logic sys_rst;
    logic ce;
    logic ce_half;
    logic running;
    logic lock_lost;

    modport master (
        output dcm_ready, lock_clr,
        input  sys_rst, ce, ce_half, running, lock_lost
    );

    modport slave (
        input  dcm_ready, lock_clr,
        output sys_rst, ce, ce_half, running, lock_lost
    );
endinterface

// File: rtl/sync_ff.sv
// sync_ff: N-stage single-bit synchronizer, all stages reset to 0.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output (last stage)
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/core_rst_ce_gen.sv
// core_rst_ce_gen: holds the core in reset until DCM lock has been stable for HOLD_CYCLES,
// then paces it with periodic clock enables; drops back to reset when lock is lost.
//   clk   - DCM doubled clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side: dcm_ready, lock_clr in; sys_rst, ce, ce_half, running, lock_lost out
module core_rst_ce_gen
    import core_clk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = HoldCyclesDef,
    parameter int unsigned CE_DIV      = CeDivDef
) (
    input  logic               clk,
    input  logic               rst_n,
    core_rst_ce_gen_if.slave   bus
);
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned DivW  = $clog2(CE_DIV);

    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(CE_DIV - 1);
    localparam logic [DivW-1:0]  DivHalf  = DivW'(CE_DIV / 2 - 1);

    logic             lock_s;
    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic             sys_rst_q, sys_rst_d;
    logic             running_q, running_d;
    logic             ce_q, ce_d;
    logic             ce_half_q, ce_half_d;
    logic             lock_lost_q, lock_lost_d;
    logic             active;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.dcm_ready),
        .q     (lock_s)
    );

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StWaitLock;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StWaitLock: begin
                hold_cnt_d = '0;
                if (lock_s) begin
                    state_d = StStabilize;
                end
            end
            StStabilize: begin
                if (!lock_s) begin
                    state_d    = StWaitLock;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d    = StRun;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                end
            end
            default: begin
                state_d    = StWaitLock;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Divider only runs once reset has been released to the core, so the first ce lands
    // exactly CE_DIV cycles after the sys_rst fall.
    assign active = (state_q == StRun) && running_q;

    // Output next-state logic.
    always_comb begin
        sys_rst_d = (state_q != StRun);
        running_d = (state_q == StRun);
        div_cnt_d = '0;
        if (active) begin
            div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
        end
        ce_d      = active && (div_cnt_q == DivLast);
        ce_half_d = active && (div_cnt_q == DivHalf);
        // running_q still high while state has left RUN marks the lock-loss edge; set wins.
        if (running_q && (state_q != StRun)) begin
            lock_lost_d = 1'b1;
        end else if (bus.lock_clr) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            sys_rst_q   <= 1'b1;
            running_q   <= 1'b0;
            ce_q        <= 1'b0;
            ce_half_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            sys_rst_q   <= sys_rst_d;
            running_q   <= running_d;
            ce_q        <= ce_d;
            ce_half_q   <= ce_half_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign bus.sys_rst   = sys_rst_q;
    assign bus.running   = running_q;
    assign bus.ce        = ce_q;
    assign bus.ce_half   = ce_half_q;
    assign bus.lock_lost = lock_lost_q;
endmodule

// File: tb/tb_core_rst_ce_gen.sv
// tb_core_rst_ce_gen: two sequencer instances (S=2/H=16/D=8 and S=3/H=5/D=2) driven with the
// same lock/clear stimulus and checked every cycle against a streak-count model.
module tb_core_rst_ce_gen;
    localparam int NI = 2;
    localparam int BSYS = 4, BRUN = 3, BCE = 2, BHALF = 1, BLL = 0;

    int sp [NI] = '{2, 3};
    int hp [NI] = '{16, 5};
    int dp [NI] = '{8, 2};

    logic clk = 1'b0;
    logic rst_n;
    logic dr, clr;

    always #5 clk = ~clk;

    core_rst_ce_gen_if bus_a ();
    core_rst_ce_gen_if bus_b ();

    core_rst_ce_gen #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .CE_DIV(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    core_rst_ce_gen #(.SYNC_STAGES(3), .HOLD_CYCLES(5), .CE_DIV(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    assign bus_a.dcm_ready = dr;
    assign bus_b.dcm_ready = dr;
    assign bus_a.lock_clr  = clr;
    assign bus_b.lock_clr  = clr;

    logic [4:0] outs [NI];
    assign outs[0] = {bus_a.sys_rst, bus_a.running, bus_a.ce, bus_a.ce_half, bus_a.lock_lost};
    assign outs[1] = {bus_b.sys_rst, bus_b.running, bus_b.ce, bus_b.ce_half, bus_b.lock_lost};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: delayed lock samples, and the length of the synced-lock streak seen by the FSM.
    // cs_n = streak length after the latest edge, cs_p = after the edge before.
    int syn  [NI][4];
    int cs_n [NI];
    int cs_p [NI];
    bit ll   [NI];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < 4; j++) syn[i][j] = 0;
            cs_n[i] = 0;
            cs_p[i] = 0;
            ll[i]   = 1'b0;
        end
    endtask

    task automatic model_edge(input logic d, input logic c);
        for (int i = 0; i < NI; i++) begin
            int  nxt;
            bit  set;
            nxt = (syn[i][sp[i]-1] != 0) ? cs_n[i] + 1 : 0;
            set = (cs_p[i] >= hp[i] + 1) && (cs_n[i] == 0);
            ll[i] = set ? 1'b1 : (c ? 1'b0 : ll[i]);
            cs_p[i] = cs_n[i];
            cs_n[i] = nxt;
            for (int j = 3; j > 0; j--) syn[i][j] = syn[i][j-1];
            syn[i][0] = int'(d);
        end
    endtask

    // Run state after edge n-1 means the core sees reset released after edge n; pulses are
    // spaced from that release by the position within the CE_DIV period.
    function automatic logic [4:0] model_out(input int i);
        logic run;
        int   x;
        run = (cs_p[i] >= hp[i] + 1);
        x   = cs_p[i] - hp[i] - 1;
        return {~run, run,
                run && (x > 0) && ((x % dp[i]) == 0),
                run && (x > 0) && ((x % dp[i]) == dp[i] / 2),
                ll[i]};
    endfunction

    task automatic chk(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        string nm [5] = '{"lock_lost", "ce_half", "ce", "running", "sys_rst"};
        for (int i = 0; i < NI; i++) begin
            logic [4:0] e;
            e = model_out(i);
            for (int b = 0; b < 5; b++) begin
                chk($sformatf("%s.%s", (i == 0) ? "a" : "b", nm[b]), outs[i][b], e[b]);
            end
        end
    endtask

    task automatic tick(input logic d, input logic c);
        dr  = d;
        clr = c;
        @(posedge clk);
        cyc++;
        model_edge(d, c);
        @(negedge clk);
        compare_all();
    endtask

    int drop_left;
    int rc;

    initial begin
        rst_n = 1'b0;
        dr    = 1'b0;
        clr   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst.sys_rst", outs[i][BSYS], 1'b1);
            chk("rst.running", outs[i][BRUN], 1'b0);
            chk("rst.ce", outs[i][BCE], 1'b0);
            chk("rst.ce_half", outs[i][BHALF], 1'b0);
            chk("rst.lock_lost", outs[i][BLL], 1'b0);
        end
        rst_n = 1'b1;

        // Lock raised, sampled at edge 10.
        while (cyc < 50) begin
            tick((cyc + 1) >= 10, 1'b0);
            if (cyc == 28) chk("a.sys_rst_28", outs[0][BSYS], 1'b1);
            if (cyc == 29) chk("a.sys_rst_29", outs[0][BSYS], 1'b0);
            if (cyc == 29) chk("a.running_29", outs[0][BRUN], 1'b1);
            if (cyc == 33) chk("a.ce_half_33", outs[0][BHALF], 1'b1);
            if (cyc == 36) chk("a.ce_36", outs[0][BCE], 1'b0);
            if (cyc == 37) chk("a.ce_37", outs[0][BCE], 1'b1);
            if (cyc == 45) chk("a.ce_45", outs[0][BCE], 1'b1);
            if (cyc == 18) chk("b.sys_rst_18", outs[1][BSYS], 1'b1);
            if (cyc == 19) chk("b.sys_rst_19", outs[1][BSYS], 1'b0);
            if (cyc == 20) chk("b.ce_half_20", outs[1][BHALF], 1'b1);
            if (cyc == 21) chk("b.ce_21", outs[1][BCE], 1'b1);
        end

        // Lock loss in RUN; clear coincides with the set edge of instance a, then clear alone.
        tick(1'b0, 1'b0);  // 51
        tick(1'b0, 1'b0);  // 52
        tick(1'b0, 1'b0);  // 53
        tick(1'b0, 1'b1);  // 54
        chk("a.lost_set_wins", outs[0][BLL], 1'b1);
        chk("a.sys_rst_lost", outs[0][BSYS], 1'b1);
        chk("a.ce_lost", outs[0][BCE], 1'b0);
        tick(1'b0, 1'b1);  // 55
        chk("a.lost_cleared", outs[0][BLL], 1'b0);
        tick(1'b0, 1'b0);  // 56

        // Re-lock from edge 57 with a one-cycle glitch sampled at edge 68.
        while (cyc < 95) begin
            tick((cyc + 1) != 68, 1'b0);
            if (cyc == 76) chk("a.glitch_sys_rst_76", outs[0][BSYS], 1'b1);
            if (cyc == 87) chk("a.glitch_sys_rst_87", outs[0][BSYS], 1'b1);
            if (cyc == 88) chk("a.glitch_sys_rst_88", outs[0][BSYS], 1'b0);
            if (cyc == 88) chk("a.glitch_lost_88", outs[0][BLL], 1'b0);
        end

        // Asynchronous reset pulse between edges while running.
        @(posedge clk);
        cyc++;
        model_edge(dr, clr);
        rc = cyc;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("a.async_sys_rst", outs[0][BSYS], 1'b1);
        chk("a.async_ce", outs[0][BCE], 1'b0);
        chk("b.async_sys_rst", outs[1][BSYS], 1'b1);
        chk("b.async_running", outs[1][BRUN], 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        compare_all();
        while (cyc < rc + 30) begin
            tick(1'b1, 1'b0);
            if (cyc == rc + 2 + 16 + 1) chk("a.rehold_sys_rst_hi", outs[0][BSYS], 1'b1);
            if (cyc == rc + 1 + 2 + 16 + 1) chk("a.rehold_sys_rst_lo", outs[0][BSYS], 1'b0);
        end

        // Randomized lock drops and clears.
        drop_left = 0;
        for (int n = 0; n < 4000; n++) begin
            logic c;
            if (drop_left == 0 && $urandom_range(0, 149) == 0) begin
                drop_left = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40)
                                                        : $urandom_range(1, 6);
            end
            c = ($urandom_range(0, 15) == 0);
            tick(drop_left == 0, c);
            if (drop_left > 0) drop_left--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
